gpp_rtr_tx_packetizer: RTL and testbench

//   Downstream of the GPP core: accepts 16-bit words the GPP emits toward the photonic router.
//   The GPP asserts a control packet (gpp_rtr_cp) or a data packet (gpp_rtr_dp/trf_dp).
//   The block buffers the words in a small FIFO and serializes each into an 8-bit flit packet.

---
 rtl/gpp_net_pkg.sv | 45 ++++
 rtl/gpp_rtr_tx_fifo.sv | 56 +++++
 rtl/gpp_rtr_tx_packetizer.sv | 135 +++++++++++++
 tb/tb_gpp_rtr_tx_packetizer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpp_net_pkg.sv
// Shared types for the GPP -> photonic router transmit path.
// Defining GPP_RTR_TX_PARITY_EN adds the PAR state for the optional parity flit.
package gpp_net_pkg;

  localparam int FLIT_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic {
    DATA = 1'b0,
    CTRL = 1'b1
  } pkt_type_e;

  typedef struct packed {
    pkt_type_e  ptype;
    logic [2:0] dest;
    logic [3:0] seq;
  } hdr_flit_t;

  typedef struct packed {
    pkt_type_e         ptype;
    logic [2:0]        dest;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY_HI,
`ifdef GPP_RTR_TX_PARITY_EN
    PAY_LO,
    PAR
`else
    PAY_LO
`endif
  } tx_state_e;

  function automatic logic [FLIT_W-1:0] make_hdr(input fifo_entry_t e, input logic [3:0] seq);
    hdr_flit_t h;
    h.ptype = e.ptype;
    h.dest  = e.dest;
    h.seq   = seq;
    return h;
  endfunction

endpackage

// File: rtl/gpp_rtr_tx_fifo.sv
// Synchronous word FIFO with combinational head output; pushes when full and
// pops when empty are ignored. DEPTH must be a power of two so pointers wrap freely.
module gpp_rtr_tx_fifo
  import gpp_net_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(fifo_entry_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is checked before any same-cycle pop, so there is no bypass path.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gpp_rtr_tx_packetizer.sv
// Buffers GPP words and serializes each into header/payload-hi/payload-lo flits.
// With GPP_RTR_TX_PARITY_EN defined a fourth parity flit closes each packet.
module gpp_rtr_tx_packetizer
  import gpp_net_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] NODE_ID    = 3'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic                          push_type,
  input  logic [2:0]                    push_dest,
  input  logic [15:0]                   push_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [FLIT_W-1:0]             tx_flit,
  output logic                          tx_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          self_dest_drop
);

  fifo_entry_t     wr_entry, head;
  logic            fifo_full, fifo_empty, pop;
  logic            head_self, fire, last_fire, pop_load, pop_drop;
  logic [3:0]      hdr_seq;

  tx_state_e       state_q;
  logic [3:0]      seq_q;
  logic            tx_valid_q, tx_last_q, drop_q;
  logic [FLIT_W-1:0] tx_flit_q, pay_hi_q, pay_lo_q;
`ifdef GPP_RTR_TX_PARITY_EN
  logic [FLIT_W-1:0] par_q;
`endif

  assign wr_entry.ptype = pkt_type_e'(push_type);
  assign wr_entry.dest  = push_dest;
  assign wr_entry.data  = push_data;

  gpp_rtr_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_valid),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // tx_last is only ever high in the final state, so it marks packet completion.
  assign fire      = tx_valid_q && tx_ready;
  assign last_fire = fire && tx_last_q;
  assign head_self = (head.dest == NODE_ID);
  assign pop_load  = !fifo_empty && !head_self && ((state_q == IDLE) || last_fire);
  assign pop_drop  = !fifo_empty && head_self && (state_q == IDLE);
  assign pop       = pop_load || pop_drop;
  assign hdr_seq   = (state_q == IDLE) ? seq_q : seq_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_flit_q  <= '0;
      drop_q     <= 1'b0;
      pay_hi_q   <= '0;
      pay_lo_q   <= '0;
`ifdef GPP_RTR_TX_PARITY_EN
      par_q      <= '0;
`endif
    end else begin
      drop_q <= pop_drop;
      if (last_fire) seq_q <= seq_q + 4'd1;
      if (pop_load) begin
        state_q    <= HDR;
        tx_valid_q <= 1'b1;
        tx_last_q  <= 1'b0;
        tx_flit_q  <= make_hdr(head, hdr_seq);
        pay_hi_q   <= head.data[15:8];
        pay_lo_q   <= head.data[7:0];
`ifdef GPP_RTR_TX_PARITY_EN
        par_q      <= make_hdr(head, hdr_seq) ^ head.data[15:8] ^ head.data[7:0];
`endif
      end else begin
        case (state_q)
          HDR: if (fire) begin
            state_q   <= PAY_HI;
            tx_flit_q <= pay_hi_q;
          end
          PAY_HI: if (fire) begin
            state_q   <= PAY_LO;
            tx_flit_q <= pay_lo_q;
`ifdef GPP_RTR_TX_PARITY_EN
            tx_last_q <= 1'b0;
`else
            tx_last_q <= 1'b1;
`endif
          end
`ifdef GPP_RTR_TX_PARITY_EN
          PAY_LO: if (fire) begin
            state_q   <= PAR;
            tx_flit_q <= par_q;
            tx_last_q <= 1'b1;
          end
          PAR: if (fire) begin
`else
          PAY_LO: if (fire) begin
`endif
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_flit_q  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign push_ready     = !fifo_full;
  assign tx_valid       = tx_valid_q;
  assign tx_flit        = tx_flit_q;
  assign tx_last        = tx_last_q;
  assign self_dest_drop = drop_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gpp_rtr_tx_packetizer.sv
// Bench for gpp_rtr_tx_packetizer: scoreboard of expected {last, flit} values
// plus a vector table and directed sequences for stall, overflow, drop and reset.
module tb_gpp_rtr_tx_packetizer;

  localparam int         DEPTH   = 4;
  localparam logic [2:0] NODE_ID = 3'd0;
`ifdef GPP_RTR_TX_PARITY_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_valid = 1'b0, push_type = 1'b0;
  logic [2:0]  push_dest = '0;
  logic [15:0] push_data = '0;
  logic        tx_ready = 1'b0;
  logic        push_ready, tx_valid, tx_last, busy, self_dest_drop;
  logic [7:0]  tx_flit;
  logic [$clog2(DEPTH):0] fifo_count;

  gpp_rtr_tx_packetizer #(.FIFO_DEPTH(DEPTH), .NODE_ID(NODE_ID)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_type(push_type),
    .push_dest(push_dest), .push_data(push_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flit(tx_flit), .tx_last(tx_last),
    .fifo_count(fifo_count), .busy(busy), .self_dest_drop(self_dest_drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int drop_cnt = 0;
  logic [8:0] exp_q[$];
  logic [3:0] m_seq = '0;
  logic rnd_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare accepted flits, hold-stability under stall, and count drop pulses.
  logic       hold_v = 1'b0;
  logic [8:0] hold_f = '0;
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("stall_hold", {tx_valid, tx_last, tx_flit}, {1'b1, hold_f});
      if (self_dest_drop) drop_cnt++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flit: got 0x%0h expected none", {tx_last, tx_flit});
        end else begin
          chk("flit", {tx_last, tx_flit}, exp_q.pop_front());
        end
      end
      hold_v = tx_valid && !tx_ready;
      hold_f = {tx_last, tx_flit};
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      tx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic expect_pkt(input logic [7:0] hdr, input logic [15:0] w);
`ifdef GPP_RTR_TX_PARITY_EN
    logic [7:0] par;
    par = hdr ^ w[15:8] ^ w[7:0];
`endif
    exp_q.push_back({1'b0, hdr});
    exp_q.push_back({1'b0, w[15:8]});
`ifdef GPP_RTR_TX_PARITY_EN
    exp_q.push_back({1'b0, w[7:0]});
    exp_q.push_back({1'b1, par});
`else
    exp_q.push_back({1'b1, w[7:0]});
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic t, input logic [2:0] d, input logic [15:0] w,
                           input logic [7:0] hdr, input logic drop);
    int n;
    n = 0;
    push_valid = 1'b1; push_type = t; push_dest = d; push_data = w;
    while (!push_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_accept", n < 200, 1);
    @(posedge clk);
    if (!drop) expect_pkt(hdr, w);
    #1;
    push_valid = 1'b0;
  endtask

  task automatic push_model(input logic t, input logic [2:0] d, input logic [15:0] w);
    logic [7:0] hdr;
    hdr = {t, d, m_seq};
    if (d != NODE_ID) m_seq = m_seq + 4'd1;
    push_word(t, d, w, hdr, d == NODE_ID);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", n < 3000, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    m_seq = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ptype;
    logic [2:0]  dest;
    logic [15:0] data;
    logic [7:0]  exp_hdr;
    logic        exp_drop;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int gap, d0, n;
    vecs[0] = '{1'b0, 3'd3, 16'h1234, 8'h30, 1'b0};
    vecs[1] = '{1'b1, 3'd7, 16'hBEEF, 8'hF1, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 16'hDEAD, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 3'd1, 16'h0000, 8'h92, 1'b0};
    vecs[4] = '{1'b0, 3'd6, 16'hFFFF, 8'h63, 1'b0};
    vecs[5] = '{1'b0, 3'd2, 16'h00FF, 8'h24, 1'b0};

    @(posedge clk); #1;
    do_reset();
    @(posedge clk); #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_flit", tx_flit, 0);
    chk("rst_drop", self_dest_drop, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_busy", busy, 0);

    // Single packet and header latency.
    tx_ready = 1'b1;
    push_model(1'b0, 3'd3, 16'hA55A);
    chk("lat_t1_valid", tx_valid, 0);
    @(posedge clk); #1;
    chk("lat_t2_valid", tx_valid, 1);
    chk("lat_t2_hdr", tx_flit, 8'h30);
    wait_drain();

    // Backpressure in PAY_HI.
    push_model(1'b0, 3'd3, 16'hA55A);
    n = 0;
    while (!(tx_valid && tx_flit == 8'hA5) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b0;
    chk("bp_reach_pay_hi", n < 50, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", tx_valid, 1);
      chk("bp_flit", tx_flit, 8'hA5);
    end
    tx_ready = 1'b1;
    wait_drain();

    // Overflow: one word is held by the FSM, DEPTH more fill the FIFO.
    tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) push_model(1'b0, 3'(i + 1), 16'($urandom));
    chk("full_push_ready", push_ready, 0);
    chk("full_count", fifo_count, DEPTH);
    push_valid = 1'b1; push_dest = 3'd4; push_data = 16'h7777;
    @(posedge clk); #1;
    push_valid = 1'b0;
    chk("refused_count", fifo_count, DEPTH);
    tx_ready = 1'b1;
    gap = 0;
    for (int i = 0; i < (DEPTH + 1) * FL; i++) begin
      if (!tx_valid) gap++;
      @(posedge clk); #1;
    end
    chk("b2b_gap", gap, 0);
    chk("b2b_done_valid", tx_valid, 0);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Reset while PAY_HI stalls with two words queued.
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_model(1'b1, 3'd2, 16'h6100 + 16'(i));
    n = 0;
    while (!tx_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("mid_pay_hi", tx_flit, 8'h61);
    chk("mid_count", fifo_count, 2);
    rst = 1'b0;
    exp_q.delete();
    m_seq = '0;
    @(posedge clk); #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);

    // Self-addressed word dropped; following packet keeps seq 0.
    d0 = drop_cnt;
    push_model(1'b0, NODE_ID, 16'h1111);
    push_model(1'b0, 3'd5, 16'h2222);
    wait_drain();
    chk("drop_pulses", drop_cnt - d0, 1);

    // Vector table from a fresh reset.
    do_reset();
    d0 = drop_cnt;
    for (int i = 0; i < 6; i++)
      push_word(vecs[i].ptype, vecs[i].dest, vecs[i].data, vecs[i].exp_hdr, vecs[i].exp_drop);
    m_seq = 4'd5;
    wait_drain();
    chk("table_drops", drop_cnt - d0, 1);

    // 17 packets with random backpressure; seq wraps past 15.
    rnd_en = 1'b1;
    for (int i = 0; i < 17; i++)
      push_model(1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), 16'($urandom));
    wait_drain();
    rnd_en = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
